// File: rtl/ex_pkg.sv
// Shared widths, operation/result-class codes and divider state type for the execute stage.
package ex_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int ALU_OP_BUS   = 8;
    localparam int ALU_SEL_BUS  = 3;

    localparam logic [ALU_OP_BUS-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALU_OP_BUS-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [ALU_OP_BUS-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALU_OP_BUS-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [ALU_OP_BUS-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [ALU_OP_BUS-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [ALU_OP_BUS-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [ALU_OP_BUS-1:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [ALU_OP_BUS-1:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [ALU_OP_BUS-1:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [ALU_OP_BUS-1:0] EXE_SUB_OP  = 8'b0010_0010;
    localparam logic [ALU_OP_BUS-1:0] EXE_ADDI_OP = 8'b0101_0101;
    localparam logic [ALU_OP_BUS-1:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [ALU_OP_BUS-1:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [ALU_OP_BUS-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALU_OP_BUS-1:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [ALU_SEL_BUS-1:0] EXE_RES_NOP        = 3'b000;
    localparam logic [ALU_SEL_BUS-1:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [ALU_SEL_BUS-1:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [ALU_SEL_BUS-1:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [ALU_SEL_BUS-1:0] EXE_RES_ARITHMETIC = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [REG_BUS-1:0] mag(input logic [REG_BUS-1:0] v, input logic is_signed);
        return (is_signed && v[REG_BUS-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_if.sv
// Decoded-op inputs from id_ex and write-back/stall outputs of the execute stage.
interface ex_if;
    import ex_pkg::*;

    logic [ALU_OP_BUS-1:0]   aluop_i;
    logic [ALU_SEL_BUS-1:0]  alusel_i;
    logic [REG_BUS-1:0]      reg1_i;
    logic [REG_BUS-1:0]      reg2_i;
    logic [REG_ADDR_BUS-1:0] wd_i;
    logic                    wreg_i;
    logic [REG_ADDR_BUS-1:0] wd_o;
    logic                    wreg_o;
    logic [REG_BUS-1:0]      wdata_o;
    logic                    stallreq;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o, stallreq
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o, stallreq
    );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider: 32 shift-subtract steps on magnitudes, sign fix-up on output.
// state    | meaning
// DIV_IDLE | waiting for start; latches operands (or the divide-by-zero result)
// DIV_BUSY | one quotient bit per cycle, cnt counts down 31..0
// DIV_DONE | result valid for one cycle; HI/LO capture it at the closing edge
module ex_div
    import ex_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_op,
    input  logic [REG_BUS-1:0] opdata1,
    input  logic [REG_BUS-1:0] opdata2,
    output logic               busy,
    output logic               done,
    output logic [63:0]        result
);

    div_state_t         state, state_nx;
    logic [4:0]         cnt;
    logic [REG_BUS-1:0] quo, rem, dvs;
    logic               neg_q, neg_r;
    logic [REG_BUS:0]   rem_sh, diff;

    assign rem_sh = {rem, quo[REG_BUS-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: if (start) state_nx = (opdata2 == '0) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt == 5'd0) state_nx = DIV_DONE;
            DIV_DONE: state_nx = DIV_IDLE;
            default:  state_nx = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    cnt <= 5'd31;
                    if (opdata2 == '0) begin
                        quo   <= '1;
                        rem   <= opdata1;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        quo   <= mag(opdata1, signed_op);
                        rem   <= '0;
                        dvs   <= mag(opdata2, signed_op);
                        neg_q <= signed_op & (opdata1[REG_BUS-1] ^ opdata2[REG_BUS-1]);
                        neg_r <= signed_op & opdata1[REG_BUS-1];
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt - 5'd1;
                    // A clear borrow bit means the trial subtraction fits.
                    if (!diff[REG_BUS]) begin
                        rem <= diff[REG_BUS-1:0];
                        quo <= {quo[REG_BUS-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[REG_BUS-1:0];
                        quo <= {quo[REG_BUS-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == DIV_BUSY);
    assign done   = (state == DIV_DONE);
    assign result = {(neg_r ? (~rem + 1'b1) : rem), (neg_q ? (~quo + 1'b1) : quo)};

endmodule

// File: rtl/ex.sv
// Execute stage: ALU result mux, add/sub overflow suppression, HI/LO and divide stall.
module ex
    import ex_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic [REG_BUS-1:0] hi, lo, sum, res;
    logic [63:0]        div_result;
    logic               div_busy, div_done, is_div, is_sub, ovf_chk, ovf;
    logic [4:0]         sh;

    assign is_div  = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
    assign is_sub  = (bus.aluop_i == EXE_SUB_OP);
    assign ovf_chk = (bus.aluop_i == EXE_ADD_OP) || (bus.aluop_i == EXE_ADDI_OP) || is_sub;
    assign sum     = is_sub ? (bus.reg1_i - bus.reg2_i) : (bus.reg1_i + bus.reg2_i);
    assign sh      = bus.reg1_i[4:0];
    assign ovf     = ((bus.reg1_i[REG_BUS-1] ^ bus.reg2_i[REG_BUS-1]) == is_sub)
                     && (sum[REG_BUS-1] != bus.reg1_i[REG_BUS-1]);

    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .signed_op (bus.aluop_i == EXE_DIV_OP),
        .opdata1   (bus.reg1_i),
        .opdata2   (bus.reg2_i),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done) begin
            hi <= div_result[63:32];
            lo <= div_result[31:0];
        end
    end

    always_comb begin
        res = '0;
        case (bus.alusel_i)
            EXE_RES_LOGIC: case (bus.aluop_i)
                EXE_OR_OP:  res = bus.reg1_i | bus.reg2_i;
                EXE_AND_OP: res = bus.reg1_i & bus.reg2_i;
                EXE_XOR_OP: res = bus.reg1_i ^ bus.reg2_i;
                default:    res = '0;
            endcase
            EXE_RES_SHIFT: case (bus.aluop_i)
                EXE_SLL_OP: res = bus.reg2_i << sh;
                EXE_SRL_OP: res = bus.reg2_i >> sh;
                EXE_SRA_OP: res = $unsigned($signed(bus.reg2_i) >>> sh);
                default:    res = '0;
            endcase
            EXE_RES_ARITHMETIC: case (bus.aluop_i)
                EXE_SLT_OP:  res = {31'b0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
                EXE_SLTU_OP: res = {31'b0, bus.reg1_i < bus.reg2_i};
                EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP: res = sum;
                default:     res = '0;
            endcase
            EXE_RES_MOVE: case (bus.aluop_i)
                EXE_MFHI_OP: res = hi;
                EXE_MFLO_OP: res = lo;
                default:     res = '0;
            endcase
            default: res = '0;
        endcase
    end

    // Divide ops stall from their first EX cycle until the DONE cycle releases the pipe.
    assign bus.stallreq = !rst && ((is_div && !div_busy && !div_done) || div_busy);
    assign bus.wd_o     = rst ? '0 : bus.wd_i;
    assign bus.wdata_o  = rst ? '0 : res;
    assign bus.wreg_o   = !rst && bus.wreg_i && !is_div && !(ovf_chk && ovf);

endmodule

// File: tb/tb_ex.sv
// Randomized and directed bench for the execute stage against a behavioural model.
module tb_ex;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    localparam longint MAX_POS = 64'sd2147483647;
    localparam longint MIN_NEG = -64'sd2147483648;

    ex_if bus();
    ex dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr);
        @(negedge clk);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = wd;
        bus.wreg_i   = wr;
        #1;
    endtask

    function automatic void alu_model(input logic [7:0] op, input logic [2:0] sel,
                                      input logic [31:0] a, input logic [31:0] b, input logic wr,
                                      output logic [31:0] res, output logic wr_o);
        longint sa, sb, s;
        int     n;
        sa = $signed(a);
        sb = $signed(b);
        n = int'(a[4:0]);
        res = '0;
        wr_o = wr;
        if (op == EXE_DIV_OP || op == EXE_DIVU_OP) wr_o = 1'b0;
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP)  res = a | b;
            if (op == EXE_AND_OP) res = a & b;
            if (op == EXE_XOR_OP) res = a ^ b;
        end else if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP) res = b << n;
            if (op == EXE_SRL_OP) res = b >> n;
            if (op == EXE_SRA_OP) res = b[31] ? ~((~b) >> n) : (b >> n);
        end else if (sel == EXE_RES_ARITHMETIC) begin
            if (op == EXE_SLT_OP)  res = (sa < sb) ? 32'd1 : 32'd0;
            if (op == EXE_SLTU_OP) res = (a < b) ? 32'd1 : 32'd0;
            if (op == EXE_ADD_OP || op == EXE_ADDI_OP || op == EXE_SUB_OP) begin
                s = (op == EXE_SUB_OP) ? (sa - sb) : (sa + sb);
                res = s[31:0];
                if (s > MAX_POS || s < MIN_NEG) wr_o = 1'b0;
            end
        end else if (sel == EXE_RES_MOVE) begin
            if (op == EXE_MFHI_OP) res = m_hi;
            if (op == EXE_MFLO_OP) res = m_lo;
        end
    endfunction

    task automatic test_reset();
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h1234, 32'hF0F0, 5'd5, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'd0 || bus.wreg_o !== 1'b0 || bus.wd_o !== 5'd0 || bus.stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got wdata=%h wreg=%b wd=%0d stall=%b need all zero",
                     bus.wdata_o, bus.wreg_o, bus.wd_o, bus.stallreq);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'd0 || bus.stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hi got %h stall=%b need 0 stall=0", bus.wdata_o, bus.stallreq);
        end
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_lo got %h need 0", bus.wdata_o);
        end
    endtask

    task automatic test_directed();
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_1234, 32'h0000_F0F0, 5'd5, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'h0000_F2F4 || bus.wreg_o !== 1'b1 || bus.wd_o !== 5'd5 || bus.stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL ori got wdata=%h wreg=%b wd=%0d stall=%b need 0000f2f4 1 5 0",
                     bus.wdata_o, bus.wreg_o, bus.wd_o, bus.stallreq);
        end
        drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd2, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL sra got %h need f8000000", bus.wdata_o);
        end
        drive(EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'd1) begin
            n_fail++;
            $display("FAIL slt got %h need 1", bus.wdata_o);
        end
        drive(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL sltu got %h need 0", bus.wdata_o);
        end
        drive(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b1);
        n_checks++;
        if (bus.wreg_o !== 1'b0 || bus.wdata_o !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL add_ovf got wreg=%b wdata=%h need 0 80000000", bus.wreg_o, bus.wdata_o);
        end
        drive(EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'd5, 32'd3, 5'd7, 1'b1);
        n_checks++;
        if (bus.wreg_o !== 1'b1 || bus.wdata_o !== 32'd2) begin
            n_fail++;
            $display("FAIL sub got wreg=%b wdata=%h need 1 2", bus.wreg_o, bus.wdata_o);
        end
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'hDEAD_BEEF, 32'h1, 5'd9, 1'b1);
        n_checks++;
        if (bus.wreg_o !== 1'b1 || bus.wdata_o !== 32'd0 || bus.stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL nop got wreg=%b wdata=%h stall=%b need 1 0 0", bus.wreg_o, bus.wdata_o, bus.stallreq);
        end
    endtask

    task automatic test_random_alu();
        logic [7:0]  ops  [12] = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
                                   EXE_SLT_OP, EXE_SLTU_OP, EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP, EXE_MFLO_OP};
        logic [2:0]  sels [12] = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_SHIFT,
                                   EXE_RES_SHIFT, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
                                   EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_MOVE};
        logic [31:0] a, b, exp_res;
        logic [4:0]  wd;
        logic        wr, exp_wr;
        int          k;
        for (int i = 0; i < 120; i++) begin
            k  = $urandom_range(11, 0);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(3, 0) == 0) a = {a[31], {31{~a[31]}}} ^ {31'b0, a[0]};
            if ($urandom_range(3, 0) == 0) b = a;
            wd = 5'($urandom);
            wr = 1'($urandom);
            alu_model(ops[k], sels[k], a, b, wr, exp_res, exp_wr);
            drive(ops[k], sels[k], a, b, wd, wr);
            n_checks++;
            if (bus.wdata_o !== exp_res || bus.wreg_o !== exp_wr || bus.wd_o !== wd || bus.stallreq !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_alu op=%h a=%h b=%h got wdata=%h wreg=%b wd=%0d stall=%b need %h %b %0d 0",
                         ops[k], a, b, bus.wdata_o, bus.wreg_o, bus.wd_o, bus.stallreq, exp_res, exp_wr, wd);
            end
        end
    endtask

    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        int     n, exp_n;
        drive(op, EXE_RES_NOP, a, b, 5'd3, 1'b1);
        n_checks++;
        if (bus.wreg_o !== 1'b0) begin
            n_fail++;
            $display("FAIL div_wreg got %b need 0", bus.wreg_o);
        end
        n = 0;
        while (bus.stallreq === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        exp_n = (b == 32'd0) ? 1 : 33;
        n_checks++;
        if (n != exp_n) begin
            n_fail++;
            $display("FAIL div_stall_cycles a=%h b=%h got %0d need %0d", a, b, n, exp_n);
        end
        if (b == 32'd0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
        end else begin
            la = (op == EXE_DIV_OP) ? longint'($signed(a)) : longint'({32'b0, a});
            lb = (op == EXE_DIV_OP) ? longint'($signed(b)) : longint'({32'b0, b});
            q  = la / lb;
            r  = la % lb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
        n_checks++;
        if (bus.wdata_o !== m_lo || bus.stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL div_lo a=%h b=%h got %h stall=%b need %h", a, b, bus.wdata_o, bus.stallreq, m_lo);
        end
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
        n_checks++;
        if (bus.wdata_o !== m_hi) begin
            n_fail++;
            $display("FAIL div_hi a=%h b=%h got %h need %h", a, b, bus.wdata_o, m_hi);
        end
    endtask

    task automatic test_div();
        do_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        do_div(EXE_DIVU_OP, 32'd100, 32'd7);
        do_div(EXE_DIVU_OP, 32'd9, 32'd0);
        do_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE);
        do_div(EXE_DIV_OP, 32'hFFFF_FFF0, 32'd0);
        do_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 6; i++)
            do_div(($urandom_range(1, 0) == 1) ? EXE_DIV_OP : EXE_DIVU_OP, $urandom,
                   ($urandom_range(1, 0) == 1) ? 32'($urandom_range(50, 1)) : $urandom);
    endtask

    task automatic test_reset_mid_div();
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd3, 1'b1);
        for (int i = 0; i < 11; i++) @(negedge clk);
        #1;
        n_checks++;
        if (bus.stallreq !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_stall got %b need 1", bus.stallreq);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.stallreq !== 1'b0 || bus.wdata_o !== 32'd0 || bus.wreg_o !== 1'b0 || bus.wd_o !== 5'd0) begin
            n_fail++;
            $display("FAIL in_reset got stall=%b wdata=%h wreg=%b wd=%0d need zeros",
                     bus.stallreq, bus.wdata_o, bus.wreg_o, bus.wd_o);
        end
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        n_checks++;
        if (bus.stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_stall got %b need 0", bus.stallreq);
        end
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'd0 || bus.stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_lo got %h stall=%b need 0 0", bus.wdata_o, bus.stallreq);
        end
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
        n_checks++;
        if (bus.wdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL after_reset_hi got %h need 0", bus.wdata_o);
        end
        do_div(EXE_DIV_OP, 32'd20, 32'd4);
    endtask

    initial begin
        bus.aluop_i  = EXE_NOP_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = '0;
        bus.reg2_i   = '0;
        bus.wd_i     = '0;
        bus.wreg_i   = 1'b0;
        test_reset();
        test_directed();
        test_random_alu();
        test_div();
        test_random_alu();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex.md
# ex

Execute stage of the 5-stage MIPS pipeline, directly downstream of decode via the `id_ex` register. It consumes the decoded op, operands and destination, and produces the write-back triple for `ex_mem` and for decode's EX forwarding path. It also owns the HI/LO registers and an iterative 32-cycle divider for DIV/DIVU. It raises `stallreq` to freeze the front of the pipe while a divide is in flight.

## Interface
- No parameters; widths from `defines.v` (`RegBus` 32, `RegAddrBus` 5, `AluOpBus` 8, `AluSelBus` 3).
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — synchronous, active-high (`RstEnable`).
- `aluop_i` in AluOpBus — operation code from `id_ex`.
- `alusel_i` in AluSelBus — result class: LOGIC, SHIFT, ARITHMETIC, MOVE, NOP.
- `reg1_i` in RegBus — operand 1 (rs, or shift amount in [4:0]).
- `reg2_i` in RegBus — operand 2 (rt, or immediate).
- `wd_i` in RegAddrBus — destination register.
- `wreg_i` in 1 — destination write enable.
- `wd_o` out RegAddrBus — equals `wd_i`.
- `wreg_o` out 1 — final write enable, after overflow/DIV suppression.
- `wdata_o` out RegBus — result.
- `stallreq` out 1 — request to hold PC, IF/ID, ID/EX.

## Operation
- Result outputs are combinational from the inputs; the divider FSM and HI/LO are the only state.
- LOGIC: OR, AND, XOR of `reg1_i`, `reg2_i`.
- SHIFT: `reg2_i` shifted by `reg1_i[4:0]`. SLL and SRL are logical; SRA is arithmetic.
- SLT: signed `reg1_i < reg2_i` gives 1, else 0. SLTU: same compare, unsigned.
- ADD/ADDI: `reg1_i + reg2_i`. SUB: `reg1_i - reg2_i`. 32-bit wrap.
- Signed overflow on ADD/ADDI/SUB forces `wreg_o`=0. There is no trap.
- MOVE: MFHI returns HI; MFLO returns LO.
- DIV/DIVU: `wreg_o`=0. The quotient is written to LO and the remainder to HI.
- Signed DIV works on magnitudes. The quotient is negated when operand signs differ. The remainder takes the dividend's sign.
- Divide by zero is a fixed result, not an error: LO=0xFFFFFFFF, HI=dividend.
- Any other `alusel_i` gives `wdata_o`=0 and `wreg_o`=`wreg_i`.
- Divider FSM states:
  - IDLE: on a DIV/DIVU op with divisor≠0, go to BUSY, latch magnitudes, count=0. With divisor=0, go to DONE and load the fixed result.
  - BUSY: one restoring shift-subtract step per cycle. At count=31, go to DONE.
  - DONE: write HI/LO at the closing edge, then go to IDLE.
- `stallreq` = 1 when (IDLE and DIV/DIVU presented) or BUSY. It is 0 in DONE, so the pipe advances on DONE's closing edge.
- Reset (any state, including mid-BUSY): FSM goes to IDLE, HI=LO=0, the partial result is discarded, no HI/LO write.
- A DIV arriving in IDLE right after DONE starts a new division.

## Timing
- Non-divide ops: zero latency, no stall.
- DIV, divisor≠0:
  - Cycle 0 (IDLE): `stallreq`=1.
  - Cycles 1–32: BUSY, `stallreq`=1.
  - Cycle 33: DONE, `stallreq`=0.
  - HI/LO are updated at the end of cycle 33.
- DIV, divisor=0: cycle 0 stalls, cycle 1 is DONE. HI/LO are updated at the end of cycle 1.
- An MFHI/MFLO in EX the cycle after DONE sees the new values. No bypass is required.
- Reset values: FSM=IDLE, HI=LO=0, `stallreq`=0.
- While `rst`=1: `wd_o`=0, `wreg_o`=0, `wdata_o`=0.

## Structure
- `defines.v` gains:
  - `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_MFHI_OP`, `EXE_MFLO_OP`
  - `EXE_RES_MOVE`
  - FSM state codes `DivIdle`, `DivBusy`, `DivDone`
- One sub-module, `ex_div`, holds the FSM, counter and dividend/remainder shift registers.
  - Inputs: `clk`, `rst`, `start`, `signed_op`, `opdata1`, `opdata2`.
  - Outputs: `busy`, `done`, `result[63:0]`.
- `ex` holds the ALU mux, overflow logic, HI/LO and the `stallreq` formation.

## Test plan
- ORI: `reg1`=0x00001234, `reg2`=0x0000F0F0, wd=5 -> `wdata_o`=0x0000F2F4, `wreg_o`=1, `wd_o`=5, `stallreq`=0.
- SRA: `reg1`=4, `reg2`=0x80000000 -> 0xF8000000. SLT with -1 vs 1 -> 1; SLTU with same operands -> 0.
- ADD: 0x7FFFFFFF+1 with `wreg_i`=1 -> `wreg_o`=0. SUB 5-3 -> 2, `wreg_o`=1.
- DIV -7/2:
  - `stallreq` high for exactly 33 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A following MFLO returns 0xFFFFFFFD.
  - DIVU 100/7 gives LO=14, HI=2.
- DIVU 9/0: `stallreq` high for 1 cycle -> LO=0xFFFFFFFF, HI=9.
- Assert `rst` at BUSY count=10:
  - Next cycle IDLE, `stallreq`=0, HI=LO=0.
  - A new DIV 20/4 then gives LO=5, HI=0.
